// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low gfedcba patterns for hex 0..F,
// the all-off blank pattern and the reader FSM states.
package seg7_pkg;

    typedef enum logic [1:0] {
        StSettle,
        StCapture,
        StHold
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index = hex value; bit0 = segment a .. bit6 = segment g, 0 = lit.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of a 7-bit segment pattern against the hex table;
// hit_o is low when the pattern matches no hex digit.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       hit_o
);

    always_comb begin
        value_o = '0;
        hit_o   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_PATTERNS[i]) begin
                value_o = 4'(i);
                hit_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment display and latches the decoded digit per position.
// Define SEG7_READER_BLANK_EN to treat the all-off pattern as a blank digit, not an error.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  SEG_IN,
    input  logic [3:0]  COMM_IN,
    output logic [15:0] DIGIT,
    output logic [3:0]  VALID,
    output logic [3:0]  ERR,
    output logic        UPDATE
);

    localparam logic [15:0] CntMax   = 16'(STABLE_CYCLES - 1);
    localparam logic [10:0] SyncInit = {4'b0000, SEG_BLANK};

    logic [10:0] sync1_q, sync2_q;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] digit_q, digit_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  err_q, err_d;
    logic        update_q, update_d;

    logic [6:0]  seg;
    logic [3:0]  comm;
    logic [3:0]  target;
    logic [3:0]  dec_value;
    logic        dec_hit;
    logic        changed;
    logic        capture;

    assign seg  = sync2_q[6:0];
    assign comm = sync2_q[10:7];

    // A single lit common or all four at once names the positions; anything else is ambiguous.
    assign target = ($onehot(comm) || comm == 4'b1111) ? comm : 4'b0000;

    // Stage 1 holds next cycle's sample, so a mismatch means the sample is about to change.
    assign changed = (sync1_q != sync2_q);

    seg7_pattern_decode u_decode (
        .seg_i   (seg),
        .value_o (dec_value),
        .hit_o   (dec_hit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StSettle: begin
                if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCapture: begin
                capture = 1'b1;
                cnt_d   = '0;
                state_d = changed ? StSettle : StHold;
            end
            StHold: begin
                if (changed) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < 4; i++) begin
            if (capture && target[i]) begin
                if (dec_hit) begin
                    digit_d[4*i +: 4] = dec_value;
                    valid_d[i]        = 1'b1;
                    err_d[i]          = 1'b0;
                end
`ifdef SEG7_READER_BLANK_EN
                else if (seg == SEG_BLANK) begin
                    valid_d[i] = 1'b0;
                    err_d[i]   = 1'b0;
                end
`endif
                else begin
                    valid_d[i] = 1'b0;
                    err_d[i]   = 1'b1;
                end
            end
        end
        update_d = capture && ({digit_d, valid_d, err_d} != {digit_q, valid_q, err_q});
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q  <= SyncInit;
            sync2_q  <= SyncInit;
            state_q  <= StSettle;
            cnt_q    <= '0;
            digit_q  <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            update_q <= 1'b0;
        end else begin
            sync1_q  <= {COMM_IN, SEG_IN};
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            update_q <= update_d;
        end
    end

    assign DIGIT  = digit_q;
    assign VALID  = valid_q;
    assign ERR    = err_q;
    assign UPDATE = update_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with STABLE_CYCLES = 16; expectations are hand-derived.
// Build with SEG7_READER_BLANK_EN defined to check the blank-digit variant.
module tb_seg7_reader;

    logic        CLK;
    logic        RST;
    logic [6:0]  SEG_IN;
    logic [3:0]  COMM_IN;
    logic [15:0] DIGIT;
    logic [3:0]  VALID;
    logic [3:0]  ERR;
    logic        UPDATE;

    int          n_tests;
    int          n_fail;
    int          upd_cnt;
    int          first_upd;
    int          consec;
    logic        prev_upd;
    logic [15:0] dig18;

    seg7_reader #(
        .STABLE_CYCLES (16)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SEG_IN  (SEG_IN),
        .COMM_IN (COMM_IN),
        .DIGIT   (DIGIT),
        .VALID   (VALID),
        .ERR     (ERR),
        .UPDATE  (UPDATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic [6:0] s, input logic [3:0] c);
        SEG_IN  = s;
        COMM_IN = c;
    endtask

    // Runs n cycles, sampling 1 ns after each rising edge; cycle k = k-th edge after the call.
    task automatic run_cycles(input int n);
        upd_cnt   = 0;
        first_upd = 0;
        consec    = 0;
        prev_upd  = 1'b0;
        dig18     = '0;
        for (int k = 1; k <= n; k++) begin
            @(posedge CLK);
            #1;
            if (k == 18) dig18 = DIGIT;
            if (UPDATE) begin
                upd_cnt++;
                if (first_upd == 0) first_upd = k;
                if (prev_upd) consec++;
            end
            prev_upd = UPDATE;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b0;
        apply(7'b1111111, 4'b0000);
        #2 RST = 1'b1;
        #1;
        check("reset_digit", 32'(DIGIT), 32'h0);
        check("reset_valid", 32'(VALID), 32'h0);
        check("reset_err", 32'(ERR), 32'h0);
        check("reset_update", 32'(UPDATE), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        run_cycles(25);
        check("idle_no_update", 32'(upd_cnt), 32'd0);

        // Digit 2 on position 0: output changes exactly at cycle 19.
        apply(7'b0100100, 4'b0001);
        run_cycles(30);
        check("d2_digit_c18", 32'(dig18), 32'h0000);
        check("d2_upd_cycle", 32'(first_upd), 32'd19);
        check("d2_upd_count", 32'(upd_cnt), 32'd1);
        check("d2_digit", 32'(DIGIT), 32'h0002);
        check("d2_valid", 32'(VALID), 32'b0001);
        check("d2_err", 32'(ERR), 32'b0000);

        // F on all four positions, then a short glitch and the same pattern again.
        apply(7'b0001110, 4'b1111);
        run_cycles(30);
        check("all_f_digit", 32'(DIGIT), 32'hFFFF);
        check("all_f_valid", 32'(VALID), 32'b1111);
        check("all_f_upd_count", 32'(upd_cnt), 32'd1);
        apply(7'b0000000, 4'b1111);
        run_cycles(3);
        check("glitch_upd", 32'(upd_cnt), 32'd0);
        apply(7'b0001110, 4'b1111);
        run_cycles(30);
        check("reheld_upd", 32'(upd_cnt), 32'd0);
        check("reheld_digit", 32'(DIGIT), 32'hFFFF);

        // Toggling faster than the stability window is never captured.
        begin
            int tog_upd;
            tog_upd = 0;
            for (int t = 0; t < 25; t++) begin
                apply(t[0] ? 7'b1111001 : 7'b0000000, 4'b1111);
                run_cycles(8);
                tog_upd += upd_cnt;
            end
            check("toggle_upd", 32'(tog_upd), 32'd0);
            check("toggle_digit", 32'(DIGIT), 32'hFFFF);
            check("toggle_valid", 32'(VALID), 32'b1111);
        end

        // Unrecognised pattern on position 2 keeps the nibble, flags the error.
        apply(7'b1010101, 4'b0100);
        run_cycles(30);
        check("bad_err", 32'(ERR), 32'b0100);
        check("bad_valid", 32'(VALID), 32'b1011);
        check("bad_digit", 32'(DIGIT), 32'hFFFF);
        check("bad_upd_count", 32'(upd_cnt), 32'd1);

        // Two commons lit: ambiguous, nothing written.
        apply(7'b0000000, 4'b0110);
        run_cycles(30);
        check("two_comm_upd", 32'(upd_cnt), 32'd0);
        check("two_comm_digit", 32'(DIGIT), 32'hFFFF);
        check("two_comm_err", 32'(ERR), 32'b0100);

        apply(7'b1111000, 4'b0010);
        run_cycles(30);
        check("d7_pos1_digit", 32'(DIGIT), 32'hFF7F);
        check("d7_pos1_upd", 32'(upd_cnt), 32'd1);

        apply(7'b0001000, 4'b0100);
        run_cycles(30);
        check("da_pos2_digit", 32'(DIGIT), 32'hFA7F);
        check("da_pos2_valid", 32'(VALID), 32'b1111);
        check("da_pos2_err", 32'(ERR), 32'b0000);

        // Long steady hold: saturated counter, no repeat capture.
        run_cycles(100);
        check("hold_upd", 32'(upd_cnt), 32'd0);

        // All segments off on position 3.
        apply(7'b1111111, 4'b1000);
        run_cycles(30);
        check("blank_digit", 32'(DIGIT), 32'hFA7F);
        check("blank_valid", 32'(VALID), 32'b0111);
`ifdef SEG7_READER_BLANK_EN
        check("blank_err", 32'(ERR), 32'b0000);
`else
        check("blank_err", 32'(ERR), 32'b1000);
`endif
        check("blank_upd_count", 32'(upd_cnt), 32'd1);

        // Reset in the middle of settling, then a full-latency capture after release.
        apply(7'b0010010, 4'b0001);
        run_cycles(10);
        #2 RST = 1'b1;
        #1;
        check("midrst_digit", 32'(DIGIT), 32'h0);
        check("midrst_valid", 32'(VALID), 32'h0);
        check("midrst_err", 32'(ERR), 32'h0);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST = 1'b0;
        run_cycles(30);
        check("postrst_digit_c18", 32'(dig18), 32'h0000);
        check("postrst_upd_cycle", 32'(first_upd), 32'd19);
        check("postrst_digit", 32'(DIGIT), 32'h0005);
        check("postrst_valid", 32'(VALID), 32'b0001);
        check("postrst_consec", 32'(consec), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, number of consecutive identical samples required before capture (range 2..65535).
REQ-002 SHALL have port CLK  input  1  system clock (12 MHz board clock).
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port SEG_IN  input  7  observed segment lines, active low, bit0=a .. bit6=g, asynchronous to CLK.
REQ-005 SHALL have port COMM_IN  input  4  observed common-anode lines, active high, asynchronous to CLK.
REQ-006 SHALL have port DIGIT  output  16  decoded hex value per position, nibble n = COMM bit n.
REQ-007 SHALL have port VALID  output  4  per-position flag: DIGIT nibble holds a decoded value.
REQ-008 SHALL have port ERR  output  4  per-position flag: last capture was an unrecognised pattern.
REQ-009 SHALL have port UPDATE  output  1  one-cycle pulse when any DIGIT/VALID/ERR bit changes.

Function
REQ-010 SHALL pass {COMM_IN, SEG_IN} through a 2-flop synchronizer; the second-stage value is the sample.
REQ-011 SHALL implement states SETTLE, CAPTURE, HOLD.
REQ-012 SETTLE: sample differs from previous cycle -> counter cleared; counter reaches STABLE_CYCLES-1 with sample unchanged -> CAPTURE.
REQ-013 CAPTURE: lasts exactly one cycle, writes outputs per REQ-015..018, then -> HOLD.
REQ-014 HOLD: sample changes -> SETTLE with counter 0; no writes in HOLD or SETTLE.
REQ-015 Decode SHALL map patterns 0..F: 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000,0001000,0000011,1000110,0100001,0000110,0001110.
REQ-016 Target set: one-hot COMM -> that position; COMM=1111 -> all four positions; any other COMM (0000, 2 or 3 bits) -> no write, no UPDATE.
REQ-017 Recognised pattern: target nibble <= value, VALID bit <= 1, ERR bit <= 0.
REQ-018 Unrecognised pattern: DIGIT nibble retained, VALID bit <= 0, ERR bit <= 1.
REQ-019 UPDATE SHALL assert the cycle after CAPTURE only if an output bit changed; never two consecutive cycles.
REQ-020 Latency input edge -> output change SHALL be 2 + STABLE_CYCLES + 1 cycles for a stable input.
REQ-021 Counter SHALL saturate, never wrap; an input toggling faster than STABLE_CYCLES SHALL never be captured.

Reset
REQ-022 RST SHALL asynchronously force DIGIT=0, VALID=0, ERR=0, UPDATE=0, state SETTLE, counter 0, synchronizer stages SEG=1111111 COMM=0000.
REQ-023 RST asserted mid-SETTLE or mid-CAPTURE SHALL abandon the capture; no partial write.

Configuration
REQ-024 Macro SEG7_READER_BLANK_EN defined: pattern 1111111 SHALL clear VALID and ERR for target positions (blank digit, no error).
REQ-025 SEG7_READER_BLANK_EN undefined: 1111111 SHALL be treated as unrecognised per REQ-018.

Structure
REQ-026 Package seg7_pkg SHALL hold the 16 segment pattern constants, SEG_BLANK, and the state enum; shared with the display driver.
REQ-027 Sub-module seg7_pattern_decode (combinational: 7-bit pattern -> 4-bit value + hit flag) SHALL be instantiated once.

Verification
REQ-028 STABLE_CYCLES=16, COMM=0001, SEG=0100100 held 30 cycles -> DIGIT[3:0]=2, VALID=0001, ERR=0000, one UPDATE at cycle 19.
REQ-029 COMM=1111, SEG=0001110 stable -> DIGIT=16'hFFFF, VALID=1111, single UPDATE; same pattern re-held after a glitch -> no UPDATE.
REQ-030 SEG alternating 0000000/1111001 every 8 cycles for 200 cycles -> no UPDATE, outputs unchanged.
REQ-031 COMM=0100, SEG=1010101 stable -> ERR=0100, VALID bit2=0, DIGIT[11:8] unchanged; COMM=0110 stable -> no write.
REQ-032 RST asserted at cycle 10 of SETTLE -> outputs 0 immediately; after release, stable input captured after full 2+16+1 cycles.
REQ-033 SEG=1111111, COMM=1000: with SEG7_READER_BLANK_EN -> VALID[3]=0, ERR[3]=0; without -> ERR[3]=1.
